// File: rtl/dma_channel_sequencer.sv
// dma_channel_sequencer: timing and priority sequencer for an 8237A-style DMA controller.
// Arbitrates four DREQ lines, runs the HRQ/HLDA handshake and steps the SI/S0/S1-S4 cycle.
module dma_channel_sequencer (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [3:0] DREQ,
   input  logic [3:0] DREQ_MASK,
   input  logic       CTRL_DIS,
   input  logic       ROT_PRI,
   input  logic [7:0] MODE_XFER,
   input  logic [3:0] MODE_BLOCK,
   input  logic [3:0] MODE_AUTOINIT,
   input  logic       TC_IN,
   input  logic       EOP_IN_N,
   input  logic       STATUS_CLR,
   input  logic       HLDA,
   output logic       HRQ,
   output logic [3:0] DACK,
   output logic [1:0] act_ch,
   output logic       idle_cycle,
   output logic       active_cycle,
   output logic       aen,
   output logic       adstb,
   output logic       ior,
   output logic       iow,
   output logic       memr,
   output logic       memw,
   output logic       eop,
   output logic       cnt_step,
   output logic [3:0] reload,
   output logic [3:0] mask_set,
   output logic [3:0] tc_status
);

   typedef enum logic [2:0] {
      ST_SI = 3'd0,
      ST_S0 = 3'd1,
      ST_S1 = 3'd2,
      ST_S2 = 3'd3,
      ST_S3 = 3'd4,
      ST_S4 = 3'd5
   } state_t;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [3:0] vreq_s;
   logic [1:0] pri_r;
   logic [1:0] pri_nxt_s;
   logic [1:0] top_s;
   logic [1:0] winner_s;
   logic [1:0] ch_nxt_s;
   logic [1:0] kind_s;
   logic [3:0] cur_oh_s;
   logic       rot_r;
   logic       eop_lat_r;
   logic       eop_lat_nxt_s;
   logic       in_xfer_s;
   logic       term_s;
   logic       done_s;
   logic       s4_exit_s;
   logic       is_read_s;
   logic       is_write_s;

   logic       hrq_nxt_s;
   logic [3:0] dack_nxt_s;
   logic       idle_nxt_s;
   logic       aen_nxt_s;
   logic       adstb_nxt_s;
   logic       ior_nxt_s;
   logic       iow_nxt_s;
   logic       memr_nxt_s;
   logic       memw_nxt_s;
   logic       eop_nxt_s;
   logic       step_nxt_s;
   logic [3:0] reload_nxt_s;
   logic [3:0] mask_nxt_s;
   logic [3:0] tc_nxt_s;

   function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
      logic [3:0] oh;
      case (ch)
         2'd0:    oh = 4'b0001;
         2'd1:    oh = 4'b0010;
         2'd2:    oh = 4'b0100;
         2'd3:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

   // Scan starts at the highest-priority channel and wraps modulo 4.
   function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] top);
      logic [1:0] win;
      logic [1:0] idx;
      logic       found;
      win   = top;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = top + i[1:0];
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [1:0] xfer_kind(input logic [7:0] mode, input logic [1:0] ch);
      logic [1:0] k;
      case (ch)
         2'd0:    k = mode[1:0];
         2'd1:    k = mode[3:2];
         2'd2:    k = mode[5:4];
         2'd3:    k = mode[7:6];
         default: k = 2'b00;
      endcase
      return k;
   endfunction

   assign vreq_s    = CTRL_DIS ? 4'b0000 : (DREQ & ~DREQ_MASK);
   assign top_s     = (ROT_PRI && rot_r) ? pri_r : 2'b00;
   assign winner_s  = pick_winner(vreq_s, top_s);
   assign term_s    = TC_IN | eop_lat_r | ~EOP_IN_N;
   assign cur_oh_s  = ch_onehot(act_ch);
   assign in_xfer_s = (state_r == ST_S1) || (state_r == ST_S2) ||
                      (state_r == ST_S3) || (state_r == ST_S4);

   // Next-state logic; losing HLDA in S1-S4 aborts straight to SI.
   always_comb begin
      state_nxt_s = state_r;
      ch_nxt_s    = act_ch;
      done_s      = 1'b0;
      s4_exit_s   = 1'b0;
      case (state_r)
         ST_SI: begin
            if (vreq_s != 4'b0000) state_nxt_s = ST_S0;
            else                   state_nxt_s = ST_SI;
         end
         ST_S0: begin
            if (vreq_s == 4'b0000) begin
               state_nxt_s = ST_SI;
            end else if (HLDA) begin
               state_nxt_s = ST_S1;
               ch_nxt_s    = winner_s;
            end else begin
               state_nxt_s = ST_S0;
            end
         end
         ST_S1: begin
            if (!HLDA) state_nxt_s = ST_SI;
            else       state_nxt_s = ST_S2;
         end
         ST_S2: begin
            if (!HLDA) state_nxt_s = ST_SI;
            else       state_nxt_s = ST_S3;
         end
         ST_S3: begin
            if (!HLDA) state_nxt_s = ST_SI;
            else       state_nxt_s = ST_S4;
         end
         ST_S4: begin
            if (!HLDA) begin
               state_nxt_s = ST_SI;
            end else begin
               s4_exit_s = 1'b1;
               if (term_s) begin
                  state_nxt_s = ST_SI;
                  done_s      = 1'b1;
               end else if (MODE_BLOCK[act_ch]) begin
                  state_nxt_s = ST_S1;
               end else begin
                  state_nxt_s = ST_SI;
               end
            end
         end
         default: state_nxt_s = ST_SI;
      endcase
   end

   // Priority pointer: fixed scheme pins it at ch0, any ROT_PRI change resets it.
   always_comb begin
      pri_nxt_s = pri_r;
      if (ROT_PRI != rot_r) begin
         pri_nxt_s = 2'b00;
      end else if (!ROT_PRI) begin
         pri_nxt_s = 2'b00;
      end else if (s4_exit_s) begin
         pri_nxt_s = act_ch + 2'd1;
      end else begin
         pri_nxt_s = pri_r;
      end
   end

   // EOP event latch, live only while a transfer cycle is running.
   always_comb begin
      eop_lat_nxt_s = eop_lat_r;
      if ((state_r == ST_S4) || (state_nxt_s == ST_SI)) begin
         eop_lat_nxt_s = 1'b0;
      end else if (in_xfer_s && !EOP_IN_N) begin
         eop_lat_nxt_s = 1'b1;
      end else begin
         eop_lat_nxt_s = eop_lat_r;
      end
   end

   assign kind_s     = xfer_kind(MODE_XFER, ch_nxt_s);
   assign is_read_s  = (kind_s == 2'b10);
   assign is_write_s = (kind_s == 2'b01);

   // Output values for the state being entered, so the registers present a Moore decode.
   always_comb begin
      hrq_nxt_s   = 1'b0;
      dack_nxt_s  = 4'b0000;
      idle_nxt_s  = 1'b1;
      aen_nxt_s   = 1'b0;
      adstb_nxt_s = 1'b0;
      ior_nxt_s   = 1'b1;
      iow_nxt_s   = 1'b1;
      memr_nxt_s  = 1'b1;
      memw_nxt_s  = 1'b1;
      eop_nxt_s   = 1'b1;
      step_nxt_s  = 1'b0;
      case (state_nxt_s)
         ST_SI: begin
            hrq_nxt_s = 1'b0;
         end
         ST_S0: begin
            hrq_nxt_s = 1'b1;
         end
         ST_S1: begin
            hrq_nxt_s   = 1'b1;
            dack_nxt_s  = ch_onehot(ch_nxt_s);
            idle_nxt_s  = 1'b0;
            aen_nxt_s   = 1'b1;
            adstb_nxt_s = 1'b1;
         end
         ST_S2: begin
            hrq_nxt_s  = 1'b1;
            dack_nxt_s = ch_onehot(ch_nxt_s);
            idle_nxt_s = 1'b0;
            aen_nxt_s  = 1'b1;
            memr_nxt_s = ~is_read_s;
            ior_nxt_s  = ~is_write_s;
         end
         ST_S3: begin
            hrq_nxt_s  = 1'b1;
            dack_nxt_s = ch_onehot(ch_nxt_s);
            idle_nxt_s = 1'b0;
            aen_nxt_s  = 1'b1;
            memr_nxt_s = ~is_read_s;
            ior_nxt_s  = ~is_write_s;
            iow_nxt_s  = ~is_read_s;
            memw_nxt_s = ~is_write_s;
         end
         ST_S4: begin
            hrq_nxt_s  = 1'b1;
            dack_nxt_s = ch_onehot(ch_nxt_s);
            idle_nxt_s = 1'b0;
            aen_nxt_s  = 1'b1;
            memr_nxt_s = ~is_read_s;
            ior_nxt_s  = ~is_write_s;
            iow_nxt_s  = ~is_read_s;
            memw_nxt_s = ~is_write_s;
            step_nxt_s = 1'b1;
            eop_nxt_s  = ~(TC_IN | eop_lat_r | ~EOP_IN_N);
         end
         default: begin
            hrq_nxt_s = 1'b0;
         end
      endcase
   end

   // Termination side effects: status set beats a same-cycle clear.
   always_comb begin
      reload_nxt_s = 4'b0000;
      mask_nxt_s   = 4'b0000;
      tc_nxt_s     = tc_status & ~{4{STATUS_CLR}};
      if (done_s) begin
         tc_nxt_s = tc_nxt_s | cur_oh_s;
         if (MODE_AUTOINIT[act_ch]) reload_nxt_s = cur_oh_s;
         else                       mask_nxt_s   = cur_oh_s;
      end else begin
         tc_nxt_s = tc_nxt_s;
      end
   end

   // State, pointer and registered outputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r      <= ST_SI;
         pri_r        <= 2'b00;
         rot_r        <= 1'b0;
         eop_lat_r    <= 1'b0;
         act_ch       <= 2'b00;
         HRQ          <= 1'b0;
         DACK         <= 4'b0000;
         idle_cycle   <= 1'b1;
         active_cycle <= 1'b0;
         aen          <= 1'b0;
         adstb        <= 1'b0;
         ior          <= 1'b1;
         iow          <= 1'b1;
         memr         <= 1'b1;
         memw         <= 1'b1;
         eop          <= 1'b1;
         cnt_step     <= 1'b0;
         reload       <= 4'b0000;
         mask_set     <= 4'b0000;
         tc_status    <= 4'b0000;
      end else begin
         state_r      <= state_nxt_s;
         pri_r        <= pri_nxt_s;
         rot_r        <= ROT_PRI;
         eop_lat_r    <= eop_lat_nxt_s;
         act_ch       <= ch_nxt_s;
         HRQ          <= hrq_nxt_s;
         DACK         <= dack_nxt_s;
         idle_cycle   <= idle_nxt_s;
         active_cycle <= ~idle_nxt_s;
         aen          <= aen_nxt_s;
         adstb        <= adstb_nxt_s;
         ior          <= ior_nxt_s;
         iow          <= iow_nxt_s;
         memr         <= memr_nxt_s;
         memw         <= memw_nxt_s;
         eop          <= eop_nxt_s;
         cnt_step     <= step_nxt_s;
         reload       <= reload_nxt_s;
         mask_set     <= mask_nxt_s;
         tc_status    <= tc_nxt_s;
      end
   end

endmodule
